// File: rtl/collision_pkg.sv
// Map geometry, tile-class encodings and the fixed wall layout for the Pac-Man collision lookup.
package collision_pkg;

  localparam int MAP_W   = 40;
  localparam int MAP_H   = 30;
  localparam int TILES   = MAP_W * MAP_H;
  localparam int START_X = 20;
  localparam int START_Y = 20;
  localparam int BAR_Y   = 10;
  localparam int BAR_X0  = 10;
  localparam int BAR_X1  = 29;

  typedef enum logic [3:0] {
    COLL_EMPTY = 4'b0000,
    COLL_WALL  = 4'b0001,
    COLL_PILL  = 4'b0010
  } collision_t;

  // Out-of-range coordinates count as wall so the mover can never leave the map.
  function automatic logic is_wall(input logic [5:0] x, input logic [4:0] y);
    int xi;
    int yi;
    xi = int'(x);
    yi = int'(y);
    if (xi >= MAP_W || yi >= MAP_H)               return 1'b1;
    if (xi == 0 || xi == MAP_W - 1)               return 1'b1;
    if (yi == 0 || yi == MAP_H - 1)               return 1'b1;
    if (yi == BAR_Y && xi >= BAR_X0 && xi <= BAR_X1) return 1'b1;
    return 1'b0;
  endfunction

endpackage

// File: rtl/collision_map_rom.sv
// Combinational map lookup: classifies a tile coordinate as wall and/or pill-bearing tile.
module collision_map_rom
  import collision_pkg::*;
(
  input  logic [5:0] x,
  input  logic [4:0] y,
  output logic       wall,
  output logic       pill_tile
);

  logic start_tile;

  assign start_tile = (int'(x) == START_X) && (int'(y) == START_Y);
  assign wall       = is_wall(x, y);
  assign pill_tile  = !wall && !start_tile;

endmodule

// File: rtl/pacman_collision_detect.sv
// Registered tile-class lookup with pill consumption and eaten-pill counter.
// Optional feature macro: COLLISION_PILL_EAT_EN (eaten bitmap and counter; otherwise pills never disappear).
module pacman_collision_detect
  import collision_pkg::*;
(
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [5:0]  next_pacman_x,
  input  logic [4:0]  next_pacman_y,
  output logic [3:0]  collision_type,
  output logic [32:0] pill_count
);

  logic       wall;
  logic       pill_tile;
  logic       is_eaten;
  collision_t next_class;

  collision_map_rom u_map (
    .x         (next_pacman_x),
    .y         (next_pacman_y),
    .wall      (wall),
    .pill_tile (pill_tile)
  );

`ifdef COLLISION_PILL_EAT_EN
  logic [TILES-1:0] eaten;
  logic [10:0]      tile_idx;

  // Only meaningful when pill_tile is set, which implies an in-range coordinate.
  assign tile_idx = 11'(next_pacman_y) * 11'(MAP_W) + 11'(next_pacman_x);
  assign is_eaten = pill_tile && eaten[tile_idx];

  // NOTE: the bitmap is flops rather than RAM on purpose, because reset must restore every pill at once.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      eaten      <= '0;
      pill_count <= '0;
    end else if (next_class == COLL_PILL) begin
      eaten[tile_idx] <= 1'b1;
      if (pill_count != '1)
        pill_count <= pill_count + 33'd1;
    end
  end
`else
  assign is_eaten   = 1'b0;
  assign pill_count = '0;
`endif

  // NOTE: default assigned first so no path through the block can infer a latch.
  always_comb begin
    next_class = COLL_EMPTY;
    if (wall)
      next_class = COLL_WALL;
    else if (pill_tile && !is_eaten)
      next_class = COLL_PILL;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)
      collision_type <= COLL_EMPTY;
    else
      collision_type <= next_class;
  end

endmodule

// File: tb/tb_pacman_collision_detect.sv
// Scoreboard bench for pacman_collision_detect; expectations come from an independent tile model.
module tb_pacman_collision_detect;

`ifdef COLLISION_PILL_EAT_EN
  localparam bit EAT_EN = 1'b1;
`else
  localparam bit EAT_EN = 1'b0;
`endif

  typedef struct {
    logic [3:0]  coll;
    logic [32:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  nx;
  logic [4:0]  ny;
  logic [3:0]  coll;
  logic [32:0] cnt;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  bit   m_eaten[40][30];
  int   m_count;

  pacman_collision_detect dut (
    .CLOCK_50       (clk),
    .reset          (reset),
    .next_pacman_x  (nx),
    .next_pacman_y  (ny),
    .collision_type (coll),
    .pill_count     (cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit model_wall(input int x, input int y);
    return x >= 40 || y >= 30 || x == 0 || x == 39 || y == 0 || y == 29 ||
           (y == 10 && x >= 10 && x <= 29);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 40; i++)
      for (int j = 0; j < 30; j++)
        m_eaten[i][j] = 1'b0;
    m_count = 0;
  endtask

  task automatic predict(input int x, input int y, output exp_t e);
    e.coll = 4'b0000;
    if (model_wall(x, y))
      e.coll = 4'b0001;
    else if (!(x == 20 && y == 20) && !m_eaten[x][y]) begin
      e.coll = 4'b0010;
      if (EAT_EN) begin
        m_eaten[x][y] = 1'b1;
        m_count++;
      end
    end
    e.cnt = 33'(m_count);
  endtask

  task automatic step(input int x, input int y);
    exp_t e;
    exp_t p;
    @(negedge clk);
    nx = 6'(x);
    ny = 5'(y);
    predict(x, y, e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    p = sb.pop_front();
    check($sformatf("type(%0d,%0d)", x, y), 64'(coll), 64'(p.coll));
    check($sformatf("count(%0d,%0d)", x, y), 64'(cnt), 64'(p.cnt));
  endtask

  initial begin
    reset = 1'b1;
    nx    = 6'd20;
    ny    = 5'd20;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("reset_type", 64'(coll), 64'd0);
    check("reset_count", 64'(cnt), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // start tile, then a pill held for three cycles
    step(20, 20);
    step(20, 19);
    step(20, 19);
    step(20, 19);

    // walls and out-of-range
    step(0, 5);
    step(39, 5);
    step(15, 10);
    step(45, 3);
    step(63, 31);
    step(10, 10);
    step(29, 10);
    step(30, 10);
    step(5, 0);
    step(5, 29);

    step(21, 20);
    step(22, 20);
    step(21, 20);

    // mid-cycle asynchronous reset after eating pills
    step(5, 5);
    step(6, 5);
    step(7, 5);
    #2;
    reset = 1'b1;
    #1;
    check("async_type", 64'(coll), 64'd0);
    check("async_count", 64'(cnt), 64'd0);
    model_clear();
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    step(7, 5);
    check("after_reset_count", 64'(cnt), EAT_EN ? 64'd1 : 64'd0);

    // full sweep twice
    for (int y = 0; y < 30; y++)
      for (int x = 0; x < 40; x++)
        step(x, y);
    check("sweep1_total", 64'(cnt), EAT_EN ? 64'd1043 : 64'd0);
    for (int y = 0; y < 30; y++)
      for (int x = 0; x < 40; x++)
        step(x, y);
    check("sweep2_total", 64'(cnt), EAT_EN ? 64'd1043 : 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
